dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the pipeline's MEM-stage load/store port.
- Accepts one doubleword request per transaction over a valid/ready handshake, services it after a fixed programmable latency from an internal array, and returns read data or an error over a valid/ready response channel.
- `busy` is the stall source for the core's hazard logic while a transaction is outstanding.

Parameters:
- DEPTH, 256, number of 64-bit doublewords in the array (power of two, ≥2).
- LATENCY, 2, clock edges from request acceptance to `rsp_valid` (1..15).
- ADDR_W, 64, byte-address width.
- DATA_W, 64, data width (fixed at 64).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1=store, 0=load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core consumes response.
- rsp_rdata  out  DATA_W  load data (0 for stores/errors).
- rsp_err  out  1  misaligned or out-of-range access.
- busy  out  1  transaction outstanding (state != IDLE).
- txn_count  out  32  completed transactions, wraps.

Behaviour:
- Reset (`rst`=0, asynchronous):
  - state IDLE; `req_ready`=1; `rsp_valid`=0; `rsp_rdata`=0; `rsp_err`=0; `busy`=0; `txn_count`=0; latency counter=0.
  - Array contents are not reset.
- Reset asserted mid-transaction aborts it. A store not yet committed is never written.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`&`req_ready`: latch we/addr/wdata; cnt<=LATENCY-1; go WAIT.
  - Error is decoded at accept: `addr[2:0]`!=0 or `addr[ADDR_W-1:3]`>=DEPTH.
- WAIT:
  - `req_ready`=0; `busy`=1.
  - cnt!=0: cnt<=cnt-1.
  - cnt==0: commit on this edge and go RESP.
    - Store without error: `mem[addr>>3]`<=wdata. `rsp_rdata`<=0.
    - Load without error: `rsp_rdata`<=`mem[addr>>3]`.
    - Error: no write, `rsp_rdata`<=0, `rsp_err`<=1.
- Latency: `rsp_valid` rises exactly LATENCY edges after the accept edge.
- RESP:
  - `rsp_valid`=1. `rsp_rdata` and `rsp_err` are stable until the handshake completes.
  - On `rsp_ready`: `rsp_valid`<=0, `rsp_err`<=0, `txn_count`<=`txn_count`+1 (mod 2^32), go IDLE.
  - A request can be accepted no earlier than the edge after the response handshake. No same-cycle turnaround.
  - `rsp_ready` held low: remain in RESP indefinitely with outputs frozen.
- `req_valid` while not ready: ignored. The core must hold the request (standard valid/ready).
- `rsp_ready` asserted outside RESP: ignored.
- Load following a store to the same address returns the stored value (commit precedes the read).
- Only index bits `addr[3+log2(DEPTH)-1:3]` select the word. Upper bits are used only for range checking.

Decomposition:
- Package `dmem_pkg`:
  - `state_t` enum (IDLE, WAIT, RESP).
  - DATA_W constant.
  - Localparam function for index width (`$clog2`).
  - Error-decode function `is_bad_addr(addr, depth)`.
- One sub-module, `dmem_array`:
  - Synchronous single-port DEPTH×64 storage.
  - Inputs: we, idx, wdata, re. Output: registered rdata.
  - No reset.
- The FSM, counter and handshakes stay in `dmem_responder`.

Test Plan:
- Reset then idle: `rst` low 2 cycles, release → `req_ready`=1, `rsp_valid`=0, `busy`=0, `txn_count`=0.
- Store/load round trip (LATENCY=2): store addr 0x10 data 0xDEADBEEF_CAFEF00D, `rsp_ready`=1 → `rsp_valid` 2 edges after accept, `rsp_err`=0. Then load 0x10 → `rsp_rdata`=0xDEADBEEFCAFEF00D, `txn_count`=2.
- Misaligned/out-of-range:
  - Store 0x13 → `rsp_err`=1, no write.
  - Load 0x800 (DEPTH=256) → `rsp_err`=1, `rsp_rdata`=0.
  - Load 0x10 afterwards → previous value unchanged.
- Response backpressure: hold `rsp_ready`=0 for 5 cycles in RESP → `rsp_valid`, `rsp_rdata` and `busy` stay constant, `req_ready`=0, and a new `req_valid` is not accepted. Raise `rsp_ready` → IDLE next edge.
- Reset mid-operation: accept store 0x20 data 0x1, assert `rst` in WAIT (LATENCY=3, cnt=1) → all outputs at reset values immediately; subsequent load 0x20 returns pre-store contents.
- Counter wrap and LATENCY=1: preload `txn_count` via 2^32-1 completed transactions (force in bench), complete one more → `txn_count`=0. With LATENCY=1, `rsp_valid` rises one edge after accept.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the MEM-stage data memory responder.
package dmem_pkg;

  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Bad if not doubleword aligned or if the word index falls past the array.
  function automatic logic is_bad_addr(input logic [63:0] addr, input int depth);
    return (addr[2:0] != 3'b000) || ((addr >> 3) >= 64'(depth));
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port doubleword storage with a registered read port; contents are never reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // rdata holds its last value whenever no read is issued.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: one doubleword transaction at a time, fixed latency,
// valid/ready on both request and response channels.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [31:0]       txn_count
);

  localparam int         IDX_W    = idx_width(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t              state;
  logic [3:0]          cnt;
  logic                we_q;
  logic                err_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                load_sel;
  logic [31:0]         txn_cnt_q;
  logic [DATA_W-1:0]   arr_rdata;
  logic                commit;
  logic                arr_we;
  logic                arr_re;

  assign commit    = (state == WAIT) && (cnt == 4'd0);
  assign arr_we    = commit && we_q && !err_q;
  assign arr_re    = commit && !we_q && !err_q;
  assign txn_count = txn_cnt_q;

  // The array read lands on the commit edge; load_sel gates it so stores,
  // errors and reset all present zero data.
  assign rsp_rdata = load_sel ? arr_rdata : '0;

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      cnt       <= 4'd0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      load_sel  <= 1'b0;
      txn_cnt_q <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            idx_q     <= req_addr[3 +: IDX_W];
            wdata_q   <= req_wdata;
            err_q     <= is_bad_addr(64'(req_addr), DEPTH);
            cnt       <= CNT_INIT;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_valid <= 1'b1;
            rsp_err   <= err_q;
            load_sel  <= !we_q && !err_q;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            txn_cnt_q <= txn_cnt_q + 32'd1;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: three responders (LATENCY 2, 3, 1) share one stimulus stream.
module tb_dmem_responder;

  localparam int NDUT = 3;

  function automatic int lat_of(input int k);
    case (k)
      0:       return 2;
      1:       return 3;
      default: return 1;
    endcase
  endfunction

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        rsp_ready = 1'b0;

  logic        req_ready [NDUT];
  logic        rsp_valid [NDUT];
  logic        rsp_err   [NDUT];
  logic        busy      [NDUT];
  logic [63:0] rsp_rdata [NDUT];
  logic [31:0] txn_count [NDUT];

  rsp_t exp_q [NDUT][$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   acc_cyc [NDUT];
  logic prev_v  [NDUT];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    dmem_responder #(
      .DEPTH   (256),
      .LATENCY (lat_of(g)),
      .ADDR_W  (64),
      .DATA_W  (64)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready[g]),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g]),
      .busy      (busy[g]),
      .txn_count (txn_count[g])
    );
  end

  task automatic checkOutput(input string name, input int k, input logic [63:0] act,
                             input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s dut%0d: got 0x%0h, expected 0x%0h", name, k, act, exp);
    end
  endtask

  // Monitor: latency from accept edge to rsp_valid rise, and scoreboard pop on handshake.
  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      if (!rst) begin
        prev_v[k] = 1'b0;
      end else begin
        if (req_valid && req_ready[k]) acc_cyc[k] = cyc + 1;
        if (rsp_valid[k] && !prev_v[k])
          checkOutput("latency", k, 64'(cyc - acc_cyc[k]), 64'(lat_of(k)));
        prev_v[k] = rsp_valid[k];
        if (rsp_valid[k] && rsp_ready) begin
          if (exp_q[k].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL unexpected_rsp dut%0d: got rdata 0x%0h, expected no response",
                     k, rsp_rdata[k]);
          end else begin
            rsp_t e;
            e = exp_q[k].pop_front();
            checkOutput("rsp_rdata", k, rsp_rdata[k], e.rdata);
            checkOutput("rsp_err", k, 64'(rsp_err[k]), 64'(e.err));
          end
        end
      end
    end
  end

  task automatic waitIdle();
    int   n;
    logic all_idle;
    n = 0;
    do begin
      @(negedge clk);
      all_idle = 1'b1;
      for (int k = 0; k < NDUT; k++)
        if (busy[k] || !req_ready[k]) all_idle = 1'b0;
      n++;
    end while (!all_idle && n < 100);
    if (!all_idle) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL idle_timeout: got busy after %0d cycles, expected idle", n);
    end
  endtask

  task automatic driveReq(input logic we, input logic [63:0] addr, input logic [63:0] wdata);
    @(posedge clk);
    #1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                               input logic err, input logic [63:0] r0, input logic [63:0] r1,
                               input logic [63:0] r2);
    waitIdle();
    exp_q[0].push_back({r0, err});
    exp_q[1].push_back({r1, err});
    exp_q[2].push_back({r2, err});
    driveReq(we, addr, wdata);
  endtask

  task automatic applyAll(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic err, input logic [63:0] r);
    applyStimulus(we, addr, wdata, err, r, r, r);
    waitIdle();
  endtask

  task automatic checkResetState(input string name);
    for (int k = 0; k < NDUT; k++) begin
      checkOutput({name, "_req_ready"}, k, 64'(req_ready[k]), 64'd1);
      checkOutput({name, "_rsp_valid"}, k, 64'(rsp_valid[k]), 64'd0);
      checkOutput({name, "_rsp_rdata"}, k, rsp_rdata[k], 64'd0);
      checkOutput({name, "_rsp_err"}, k, 64'(rsp_err[k]), 64'd0);
      checkOutput({name, "_busy"}, k, 64'(busy[k]), 64'd0);
      checkOutput({name, "_txn_count"}, k, 64'(txn_count[k]), 64'd0);
    end
  endtask

  task automatic checkCount(input string name, input logic [31:0] exp);
    for (int k = 0; k < NDUT; k++)
      checkOutput(name, k, 64'(txn_count[k]), 64'(exp));
  endtask

  localparam logic [63:0] D_10  = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [63:0] D_7F8 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D_20  = 64'h5555_AAAA_5555_AAAA;

  initial begin
    int   n;
    logic all_v;

    rst       = 1'b0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkResetState("reset");

    // Store/load round trip.
    applyAll(1'b1, 64'h10, D_10, 1'b0, 64'd0);
    applyAll(1'b0, 64'h10, 64'd0, 1'b0, D_10);
    checkCount("txn_after_roundtrip", 32'd2);

    // Misaligned store to word 2 and an out-of-range store that aliases word 2 must not write.
    applyAll(1'b1, 64'h13, 64'h1234, 1'b1, 64'd0);
    applyAll(1'b0, 64'h800, 64'd0, 1'b1, 64'd0);
    applyAll(1'b1, 64'h7F8, D_7F8, 1'b0, 64'd0);
    applyAll(1'b0, 64'h7F8, 64'd0, 1'b0, D_7F8);
    applyAll(1'b1, 64'h810, 64'h9999, 1'b1, 64'd0);
    applyAll(1'b0, 64'h10, 64'd0, 1'b0, D_10);
    checkCount("txn_after_errors", 32'd8);

    // Response backpressure with a second request held on the request channel.
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    applyStimulus(1'b0, 64'h7F8, 64'd0, 1'b0, D_7F8, D_7F8, D_7F8);
    n = 0;
    do begin
      @(negedge clk);
      all_v = 1'b1;
      for (int k = 0; k < NDUT; k++)
        if (!rsp_valid[k]) all_v = 1'b0;
      n++;
    end while (!all_v && n < 50);
    if (!all_v) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL rsp_timeout: got rsp_valid low after %0d cycles, expected high", n);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) exp_q[k].push_back({D_10, 1'b0});
    req_we    = 1'b0;
    req_addr  = 64'h10;
    req_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
        checkOutput("bp_rsp_valid", k, 64'(rsp_valid[k]), 64'd1);
        checkOutput("bp_rsp_rdata", k, rsp_rdata[k], D_7F8);
        checkOutput("bp_busy", k, 64'(busy[k]), 64'd1);
        checkOutput("bp_req_ready", k, 64'(req_ready[k]), 64'd0);
      end
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      checkOutput("bp_release_busy", k, 64'(busy[k]), 64'd0);
      checkOutput("bp_release_req_ready", k, 64'(req_ready[k]), 64'd1);
      checkOutput("bp_release_rsp_valid", k, 64'(rsp_valid[k]), 64'd0);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    waitIdle();
    checkCount("txn_after_backpressure", 32'd10);

    // Reset one edge after accept: the LATENCY=3 unit sits at cnt=1, LATENCY=2 has not
    // committed, but LATENCY=1 already committed its store on that edge.
    applyAll(1'b1, 64'h20, D_20, 1'b0, 64'd0);
    driveReq(1'b1, 64'h20, 64'h1);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 checkResetState("mid_reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    applyStimulus(1'b0, 64'h20, 64'd0, 1'b0, D_20, D_20, 64'h1);
    waitIdle();
    checkCount("txn_after_mid_reset", 32'd1);

    // Counter wrap from a preloaded all-ones count.
    force g_dut[0].u_dut.txn_cnt_q = 32'hFFFF_FFFF;
    force g_dut[1].u_dut.txn_cnt_q = 32'hFFFF_FFFF;
    force g_dut[2].u_dut.txn_cnt_q = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release g_dut[0].u_dut.txn_cnt_q;
    release g_dut[1].u_dut.txn_cnt_q;
    release g_dut[2].u_dut.txn_cnt_q;
    @(negedge clk);
    checkCount("txn_preload", 32'hFFFF_FFFF);
    applyAll(1'b1, 64'h18, 64'h42, 1'b0, 64'd0);
    checkCount("txn_wrap", 32'd0);
    applyAll(1'b0, 64'h18, 64'd0, 1'b0, 64'h42);
    checkCount("txn_after_wrap", 32'd1);

    repeat (3) @(negedge clk);
    for (int k = 0; k < NDUT; k++)
      checkOutput("queue_empty", k, 64'(exp_q[k].size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion by %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
